// File: rtl/synth_pkg.sv
// Shared widths, gate FSM state encoding and MIDI constants for the note/gate path.
package synth_pkg;
  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam int CNT_W  = 5;

  // A note-on carrying this velocity is a note-off in MIDI running-status practice.
  localparam logic [VEL_W-1:0] VEL_OFF = '0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } gate_state_e;
endpackage

// File: rtl/note_stack.sv
// Last-note-priority stack: index 0 is the sounding note; removals compact toward 0.
module note_stack
  import synth_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push_i,
  input  logic              remove_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [VEL_W-1:0]  vel_i,
  output logic              match_o,
  output logic [NOTE_W-1:0] nxt_note_o,
  output logic [VEL_W-1:0]  nxt_vel_o,
  output logic [CNT_W-1:0]  nxt_held_o,
  output logic [CNT_W-1:0]  held_o
);
  logic [NOTE_W-1:0] note_q [DEPTH];
  logic [VEL_W-1:0]  vel_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_q;
  logic [NOTE_W-1:0] note_d [DEPTH];
  logic [VEL_W-1:0]  vel_d  [DEPTH];
  logic [CNT_W-1:0]  cnt_d;
  logic [NOTE_W-1:0] rn [DEPTH];
  logic [VEL_W-1:0]  rv [DEPTH];
  logic [CNT_W-1:0]  rcnt;
  logic [CNT_W-1:0]  midx;
  logic              found;

  always_comb begin
    found = 1'b0;
    midx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && (i < int'(cnt_q)) && (note_q[i] == note_i)) begin
        found = 1'b1;
        midx  = CNT_W'(i);
      end
    end
    // Copy of the stack with the matching entry removed and the rest compacted.
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (found && (i >= int'(midx))) begin
        rn[i] = note_q[i+1];
        rv[i] = vel_q[i+1];
      end else begin
        rn[i] = note_q[i];
        rv[i] = vel_q[i];
      end
    end
    rn[DEPTH-1] = note_q[DEPTH-1];
    rv[DEPTH-1] = vel_q[DEPTH-1];
    rcnt = cnt_q - CNT_W'(found);

    note_d = note_q;
    vel_d  = vel_q;
    cnt_d  = cnt_q;
    if (push_i) begin
      note_d[0] = note_i;
      vel_d[0]  = vel_i;
      for (int i = 1; i < DEPTH; i++) begin
        note_d[i] = rn[i-1];
        vel_d[i]  = rv[i-1];
      end
      // A full stack with no match simply loses its bottom entry in the shift.
      cnt_d = (rcnt == CNT_W'(DEPTH)) ? rcnt : rcnt + 1'b1;
    end else if (remove_i && found) begin
      note_d = rn;
      vel_d  = rv;
      cnt_d  = rcnt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        note_q[i] <= '0;
        vel_q[i]  <= '0;
      end
      cnt_q <= '0;
    end else begin
      note_q <= note_d;
      vel_q  <= vel_d;
      cnt_q  <= cnt_d;
    end
  end

  assign match_o    = found;
  assign nxt_note_o = note_d[0];
  assign nxt_vel_o  = vel_d[0];
  assign nxt_held_o = cnt_d;
  assign held_o     = cnt_q;
endmodule

// File: rtl/note_gate_mgr.sv
// Monophonic gate manager: turns MIDI note events into GATE/GATEchgd/NOTE/VEL for the ADSR.
module note_gate_mgr
  import synth_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 2,
  parameter bit LEGATO     = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ev_valid,
  input  logic              ev_on,
  input  logic [NOTE_W-1:0] ev_note,
  input  logic [VEL_W-1:0]  ev_vel,
  output logic              GATE,
  output logic              GATEchgd,
  output logic [NOTE_W-1:0] NOTE,
  output logic [VEL_W-1:0]  VEL,
  output logic [CNT_W-1:0]  held,
  output gate_state_e       dbg_state
);
  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  gate_state_e       state_q, state_d;
  logic              gate_q, gate_d, chgd_q, chgd_d;
  logic [7:0]        gap_q, gap_d;
  logic [NOTE_W-1:0] note_q, note_d, nxt_note;
  logic [VEL_W-1:0]  vel_q, vel_d, nxt_vel;
  logic [CNT_W-1:0]  nxt_held, held_cur;
  logic              s_match, on_eff, changed, top_chg, emptied;

  assign on_eff = ev_on && (ev_vel != VEL_OFF);

  note_stack #(.DEPTH(DEPTH)) u_stack (
    .clock      (clock),
    .reset_n    (reset_n),
    .push_i     (ev_valid && on_eff),
    .remove_i   (ev_valid && !on_eff),
    .note_i     (ev_note),
    .vel_i      (ev_vel),
    .match_o    (s_match),
    .nxt_note_o (nxt_note),
    .nxt_vel_o  (nxt_vel),
    .nxt_held_o (nxt_held),
    .held_o     (held_cur)
  );

  // While held>0 note_q mirrors the stack top, so a matching off of note_q pops the top.
  assign changed = ev_valid && (on_eff || s_match);
  assign top_chg = ev_valid && (on_eff || (s_match && (ev_note == note_q) && (nxt_held != '0)));
  assign emptied = changed && (nxt_held == '0);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    chgd_d  = 1'b0;
    gap_d   = gap_q;
    note_d  = (nxt_held != '0) ? nxt_note : note_q;
    vel_d   = (nxt_held != '0) ? nxt_vel : vel_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_valid && on_eff) begin
          gate_d  = 1'b1;
          chgd_d  = 1'b1;
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (emptied) begin
          gate_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (top_chg && !LEGATO) begin
          gate_d  = 1'b0;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (emptied) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else if (changed) begin
          gap_d = GAP_LOAD;
        end else if (gap_q == '0) begin
          gate_d  = 1'b1;
          chgd_d  = 1'b1;
          state_d = ST_ON;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      gate_q  <= 1'b0;
      chgd_q  <= 1'b0;
      gap_q   <= '0;
      note_q  <= '0;
      vel_q   <= '0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      chgd_q  <= chgd_d;
      gap_q   <= gap_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
    end
  end

  assign GATE      = gate_q;
  assign GATEchgd  = chgd_q;
  assign NOTE      = note_q;
  assign VEL       = vel_q;
  assign held      = held_cur;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_note_gate_mgr.sv
// Drives one event stream into a retrigger and a legato instance and scoreboards both against a queue-level model.
module tb_note_gate_mgr;
  import synth_pkg::*;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int W     = 21;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ev_valid = 1'b0;
  logic       ev_on = 1'b0;
  logic [6:0] ev_note = '0;
  logic [6:0] ev_vel = '0;

  logic        gate [2];
  logic        chgd [2];
  logic [6:0]  note [2];
  logic [6:0]  vel  [2];
  logic [4:0]  held [2];
  gate_state_e st   [2];

  note_gate_mgr #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .LEGATO(1'b0)) u_dut0 (
    .clock(clock), .reset_n(reset_n), .ev_valid(ev_valid), .ev_on(ev_on),
    .ev_note(ev_note), .ev_vel(ev_vel), .GATE(gate[0]), .GATEchgd(chgd[0]),
    .NOTE(note[0]), .VEL(vel[0]), .held(held[0]), .dbg_state(st[0])
  );
  note_gate_mgr #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .LEGATO(1'b1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .ev_valid(ev_valid), .ev_on(ev_on),
    .ev_note(ev_note), .ev_vel(ev_vel), .GATE(gate[1]), .GATEchgd(chgd[1]),
    .NOTE(note[1]), .VEL(vel[1]), .held(held[1]), .dbg_state(st[1])
  );

  always #10 clock = ~clock;

  // Reference model: held notes as a list (front = most recent), gate level, pending gap length.
  logic [6:0] m_n [2][DEPTH];
  logic [6:0] m_v [2][DEPTH];
  int         m_cnt [2];
  bit         m_gate [2];
  bit         m_chg [2];
  int         m_gap [2];
  logic [6:0] m_note [2];
  logic [6:0] m_vel [2];

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  task automatic model_step(input int l, input bit rst_n, input bit v, input bit on,
                            input logic [6:0] n, input logic [6:0] vv);
    int idx;
    bit on_eff, changed, top_chg, emptied;
    if (!rst_n) begin
      m_cnt[l] = 0; m_gate[l] = 0; m_chg[l] = 0; m_gap[l] = -1;
      m_note[l] = 0; m_vel[l] = 0;
      return;
    end
    m_chg[l] = 0;
    changed = 0; top_chg = 0;
    on_eff = on && (vv != 0);
    idx = -1;
    for (int i = 0; i < m_cnt[l]; i++) if (idx < 0 && m_n[l][i] == n) idx = i;
    if (v && (on_eff || idx >= 0)) begin
      if (idx >= 0) begin
        for (int i = idx; i < m_cnt[l] - 1; i++) begin
          m_n[l][i] = m_n[l][i+1]; m_v[l][i] = m_v[l][i+1];
        end
        m_cnt[l]--;
      end
      changed = 1;
      if (on_eff) begin
        if (m_cnt[l] == DEPTH) m_cnt[l]--;
        for (int i = m_cnt[l]; i > 0; i--) begin
          m_n[l][i] = m_n[l][i-1]; m_v[l][i] = m_v[l][i-1];
        end
        m_n[l][0] = n; m_v[l][0] = vv;
        m_cnt[l]++;
        top_chg = 1;
      end else begin
        top_chg = (idx == 0) && (m_cnt[l] > 0);
      end
    end
    emptied = changed && (m_cnt[l] == 0);
    if (m_gate[l]) begin
      if (emptied) m_gate[l] = 0;
      else if (top_chg && l == 0) begin m_gate[l] = 0; m_gap[l] = GAP - 1; end
    end else if (m_gap[l] >= 0) begin
      if (emptied) m_gap[l] = -1;
      else if (changed) m_gap[l] = GAP - 1;
      else if (m_gap[l] == 0) begin m_gate[l] = 1; m_chg[l] = 1; m_gap[l] = -1; end
      else m_gap[l]--;
    end else if (v && on_eff) begin
      m_gate[l] = 1; m_chg[l] = 1;
    end
    if (m_cnt[l] > 0) begin m_note[l] = m_n[l][0]; m_vel[l] = m_v[l][0]; end
  endtask

  function automatic logic [W-1:0] model_vec(input int l);
    return {m_gate[l], m_chg[l], m_note[l], m_vel[l], 5'(m_cnt[l])};
  endfunction

  task automatic cyc(input bit rst_n, input bit v, input bit on, input logic [6:0] n, input logic [6:0] vv);
    @(negedge clock);
    reset_n = rst_n; ev_valid = v; ev_on = on; ev_note = n; ev_vel = vv;
    for (int l = 0; l < 2; l++) model_step(l, rst_n, v, on, n, vv);
    exp_q0.push_back(model_vec(0));
    exp_q1.push_back(model_vec(1));
  endtask

  task automatic note_on(input logic [6:0] n, input logic [6:0] vv);
    cyc(1'b1, 1'b1, 1'b1, n, vv);
  endtask
  task automatic note_off(input logic [6:0] n);
    cyc(1'b1, 1'b1, 1'b0, n, 7'd0);
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b1, 1'b0, 1'b0, 7'd0, 7'd0);
  endtask

  task automatic compare(input int l, input logic [W-1:0] e);
    logic [W-1:0] a;
    a = {gate[l], chgd[l], note[l], vel[l], held[l]};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL outputs dut%0d t=%0t: got gate=%b chg=%b note=%0d vel=%0d held=%0d, required gate=%b chg=%b note=%0d vel=%0d held=%0d",
               l, $time, a[20], a[19], a[18:12], a[11:5], a[4:0], e[20], e[19], e[18:12], e[11:5], e[4:0]);
    end
  endtask

  always @(posedge clock) begin
    #1;
    if (exp_q0.size() > 0) compare(0, exp_q0.pop_front());
    if (exp_q1.size() > 0) compare(1, exp_q1.pop_front());
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
    idle(2);
    note_on(7'd60, 7'd100); idle(3); note_off(7'd60); idle(3);
    note_on(7'd60, 7'd100); idle(3); note_on(7'd64, 7'd80); idle(5);
    note_off(7'd64); idle(5); note_off(7'd60); idle(3);
    for (int n = 60; n <= 68; n++) note_on(7'(n), 7'(n - 10));
    idle(4);
    for (int n = 68; n >= 61; n--) begin note_off(7'(n)); idle(4); end
    note_on(7'd60, 7'd0); idle(2);
    note_on(7'd60, 7'd100); idle(3); note_off(7'd70); idle(2);
    note_on(7'd60, 7'd90); idle(5); note_off(7'd60); idle(3);
    note_on(7'd60, 7'd100); idle(3); note_on(7'd64, 7'd80);
    cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0); cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0); idle(4);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0)
        cyc(1'b0, 1'b0, 1'b0, 7'd0, 7'd0);
      else if ($urandom_range(0, 1) == 0)
        idle(1);
      else
        cyc(1'b1, 1'b1, ($urandom_range(0, 9) < 6), 7'($urandom_range(60, 71)),
            ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 127)));
    end
    idle(3);
    @(posedge clock); #2;
    checks++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d entries left, required 0/0", exp_q0.size(), exp_q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
